// File: rtl/fft8_result_reader.sv
// rtl/fft8_result_reader.sv - snapshots eight parallel FFT results on done and streams them out one per transfer
module fft8_result_reader #(
  parameter int DATA_W = 16,
  parameter bit BITREV = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done,
  input  logic [DATA_W-1:0] fft_out0,
  input  logic [DATA_W-1:0] fft_out1,
  input  logic [DATA_W-1:0] fft_out2,
  input  logic [DATA_W-1:0] fft_out3,
  input  logic [DATA_W-1:0] fft_out4,
  input  logic [DATA_W-1:0] fft_out5,
  input  logic [DATA_W-1:0] fft_out6,
  input  logic [DATA_W-1:0] fft_out7,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] buf_q [8];
  logic [DATA_W-1:0] buf_d [8];

  logic       cap;
  logic       xfer;
  logic       fin;
  logic       load;
  logic       set_ovr;
  logic [2:0] pos;

  always_comb begin
    cap     = done & ~done_q;
    xfer    = (state_q == STREAM) & out_ready;
    fin     = xfer & (cnt_q == 3'd7);
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done;
    load    = 1'b0;
    set_ovr = 1'b0;
    buf_d   = buf_q;

    case (state_q)
      IDLE: begin
        if (cap) begin
          load    = 1'b1;
          cnt_d   = 3'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // A capture landing exactly on the final transfer starts the next frame seamlessly.
        if (cap & ~fin) begin
          set_ovr = 1'b1;
        end
        if (xfer) begin
          if (!fin) begin
            cnt_d = cnt_q + 3'd1;
          end else if (cap) begin
            load  = 1'b1;
            cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    if (load) begin
      buf_d[0] = fft_out0;
      buf_d[1] = fft_out1;
      buf_d[2] = fft_out2;
      buf_d[3] = fft_out3;
      buf_d[4] = fft_out4;
      buf_d[5] = fft_out5;
      buf_d[6] = fft_out6;
      buf_d[7] = fft_out7;
    end

    overrun_d = set_ovr ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
    end
  end

  // Outputs decode registered state only, so an async reset clears them between edges.
  always_comb begin
    pos       = BITREV ? {cnt_q[0], cnt_q[1], cnt_q[2]} : cnt_q;
    out_valid = (state_q == STREAM);
    out_index = out_valid ? pos : 3'd0;
    out_data  = out_valid ? buf_q[pos] : '0;
    out_last  = out_valid & (cnt_q == 3'd7);
    busy      = out_valid;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_fft8_result_reader.sv
// tb/tb_fft8_result_reader.sv - bench for fft8_result_reader in natural and bit-reversed order
module tb_fft8_result_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [15:0] fo [8];

  logic [15:0] o0_data, o1_data;
  logic [2:0]  o0_index, o1_index;
  logic        o0_valid, o1_valid, o0_last, o1_last;
  logic        o0_busy, o1_busy, o0_ovr, o1_ovr;

  int tests = 0;
  int fails = 0;

  localparam int BR [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft8_result_reader #(.DATA_W(16), .BITREV(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .done(done),
    .fft_out0(fo[0]), .fft_out1(fo[1]), .fft_out2(fo[2]), .fft_out3(fo[3]),
    .fft_out4(fo[4]), .fft_out5(fo[5]), .fft_out6(fo[6]), .fft_out7(fo[7]),
    .out_data(o0_data), .out_index(o0_index), .out_valid(o0_valid), .out_ready(out_ready),
    .out_last(o0_last), .busy(o0_busy), .overrun(o0_ovr), .clr_overrun(clr_overrun)
  );

  fft8_result_reader #(.DATA_W(16), .BITREV(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .done(done),
    .fft_out0(fo[0]), .fft_out1(fo[1]), .fft_out2(fo[2]), .fft_out3(fo[3]),
    .fft_out4(fo[4]), .fft_out5(fo[5]), .fft_out6(fo[6]), .fft_out7(fo[7]),
    .out_data(o1_data), .out_index(o1_index), .out_valid(o1_valid), .out_ready(out_ready),
    .out_last(o1_last), .busy(o1_busy), .overrun(o1_ovr), .clr_overrun(clr_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one held frame, a count of samples already handed over, sticky overrun flag.
  logic [15:0] m_frame [8];
  int          m_sent;
  bit          m_active, m_ovr, m_dprev;
  bit          m_cap, m_xfer, m_fin, m_was;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_sent   = 0;
      m_ovr    = 1'b0;
      m_dprev  = 1'b0;
    end else begin
      m_cap  = done && !m_dprev;
      m_was  = m_active;
      m_xfer = m_active && out_ready;
      m_fin  = m_xfer && (m_sent == 7);
      if (m_xfer) begin
        m_sent++;
        if (m_fin) m_active = 1'b0;
      end
      if (m_cap && (!m_was || m_fin)) begin
        for (int i = 0; i < 8; i++) m_frame[i] = fo[i];
        m_active = 1'b1;
        m_sent   = 0;
      end
      if (clr_overrun) m_ovr = 1'b0;
      if (m_cap && m_was && !m_fin) m_ovr = 1'b1;
      m_dprev = done;
    end
  end

  function automatic logic [22:0] model_out(input bit br);
    int p;
    if (!m_active) return {1'b0, 1'b0, m_ovr, 1'b0, 3'd0, 16'd0};
    p = br ? BR[m_sent] : m_sent;
    return {1'b1, 1'b1, m_ovr, (m_sent == 7), 3'(p), m_frame[p]};
  endfunction

  logic [19:0] log0 [$];
  logic [19:0] log1 [$];

  always @(negedge clk) begin
    chk("dut0_outputs", {9'd0, o0_valid, o0_busy, o0_ovr, o0_last, o0_index, o0_data}, {9'd0, model_out(1'b0)});
    chk("dut1_outputs", {9'd0, o1_valid, o1_busy, o1_ovr, o1_last, o1_index, o1_data}, {9'd0, model_out(1'b1)});
    if (o0_valid && out_ready) log0.push_back({o0_last, o0_index, o0_data});
    if (o1_valid && out_ready) log1.push_back({o1_last, o1_index, o1_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  logic [15:0] br_data [8] = '{16'h0100, 16'h0500, 16'h0300, 16'h0700,
                               16'h0200, 16'h0600, 16'h0400, 16'h0800};

  initial begin
    int s, s1, c;
    for (int k = 0; k < 8; k++) fo[k] = 16'h0;

    // reset and idle
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_valid", o0_valid, 0);
    chk("idle_busy", o0_busy, 0);
    chk("idle_overrun", o0_ovr, 0);
    chk("idle_data", o0_data, 0);

    // natural order, no backpressure
    for (int k = 0; k < 8; k++) fo[k] = 16'(256 * (k + 1));
    out_ready = 1'b1;
    s = log0.size();
    pulse_done();
    c = 0;
    while (log0.size() - s < 8 && c < 20) begin tick(); c++; end
    chk("nat_count", log0.size() - s, 8);
    if (log0.size() - s >= 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("nat_sample%0d", k), log0[s+k], {(k == 7), 3'(k), 16'(256 * (k + 1))});
    end
    chk("nat_busy_fall", o0_busy, 0);

    // bit-reversed with stall pattern 1,0,0
    s1 = log1.size();
    pulse_done();
    c = 0;
    while (log1.size() - s1 < 8 && c < 60) begin
      out_ready = (c % 3 == 0);
      tick();
      c++;
    end
    chk("br_count", log1.size() - s1, 8);
    if (log1.size() - s1 >= 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("br_sample%0d", k), log1[s1+k], {(k == 7), 3'(BR[k]), br_data[k]});
    end

    // level-held done, then overrun mid-frame
    out_ready = 1'b0;
    done = 1'b1;
    repeat (20) tick();
    chk("level_valid", o0_valid, 1);
    chk("level_index", o0_index, 0);
    chk("level_overrun", o0_ovr, 0);
    done = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) fo[k] = 16'hAA00 + 16'(k);
    pulse_done();
    chk("ovr_set", o0_ovr, 1);
    chk("ovr_keep_data0", o0_data, 16'h0400);
    chk("ovr_keep_data1", o1_data, 16'h0700);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clear", o0_ovr, 0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("ovr_drained", o0_busy, 0);

    // back-to-back frames
    for (int k = 0; k < 8; k++) fo[k] = 16'h1000 + 16'(k);
    s = log0.size();
    pulse_done();
    c = 0;
    while (!o0_last && c < 20) begin tick(); c++; end
    chk("b2b_reach_last", o0_last, 1);
    for (int k = 0; k < 8; k++) fo[k] = 16'h2000 + 16'(k);
    pulse_done();
    chk("b2b_valid", o0_valid, 1);
    chk("b2b_first", {o0_index, o0_data}, {3'd0, 16'h2000});
    repeat (8) tick();
    chk("b2b_count", log0.size() - s, 16);
    chk("b2b_overrun", o0_ovr, 0);

    // async reset mid-frame
    for (int k = 0; k < 8; k++) fo[k] = 16'h3000 + 16'(k);
    pulse_done();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid0", o0_valid, 0);
    chk("rst_busy0", o0_busy, 0);
    chk("rst_valid1", o1_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_idle", o0_valid, 0);
    for (int k = 0; k < 8; k++) fo[k] = 16'h4000 + 16'(k);
    s = log0.size();
    pulse_done();
    tick();
    chk("rst_new_first", (log0.size() > s) ? log0[s] : 20'hFFFFF, {1'b0, 3'd0, 16'h4000});

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      done        = ($urandom_range(0, 4) == 0) ? ~done : done;
      clr_overrun = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 8; k++) fo[k] = 16'($urandom);
      tick();
    end
    done = 1'b0;
    clr_overrun = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
